// File: rtl/median_filter_pkg.sv
// rtl/median_filter_pkg.sv - shared types and constants for the median-filter frame sequencer
package median_filter_pkg;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_RUN   = 2'd1,
        SEQ_FLUSH = 2'd2,
        SEQ_DONE  = 2'd3
    } seq_state_e;

    typedef struct packed {
        logic sof;
        logic eol;
        logic eof;
        logic bord;
        logic flush;
    } seq_tag_t;

    localparam int MIN_DIM = 3;
    localparam int DEF_IW  = 640;
    localparam int DEF_IH  = 480;

endpackage

// File: rtl/median_filter_seq_oreg.sv
// rtl/median_filter_seq_oreg.sv - single-stage output register for pixel data, coordinates and tags
module median_filter_seq_oreg
    import median_filter_pkg::*;
#(
    parameter int DW_PX  = 8,
    parameter int DW_DIM = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_i,
    input  logic [DW_PX-1:0]  dat_i,
    input  logic [DW_DIM-1:0] x_i,
    input  logic [DW_DIM-1:0] y_i,
    input  seq_tag_t          tag_i,
    input  logic              rdy_i,
    output logic              free_o,
    output logic              vld_o,
    output logic [DW_PX-1:0]  dat_o,
    output logic [DW_DIM-1:0] x_o,
    output logic [DW_DIM-1:0] y_o,
    output seq_tag_t          tag_o
);

    logic              vld_q;
    logic              vld_d;
    logic [DW_PX-1:0]  dat_q;
    logic [DW_DIM-1:0] x_q;
    logic [DW_DIM-1:0] y_q;
    seq_tag_t          tag_q;

    // The register may be refilled in the same cycle its current beat is taken.
    assign free_o = !vld_q || rdy_i;
    assign vld_d  = ld_i || (vld_q && !rdy_i);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= 1'b0;
            dat_q <= '0;
            x_q   <= '0;
            y_q   <= '0;
            tag_q <= '0;
        end else begin
            vld_q <= vld_d;
            if (ld_i) begin
                dat_q <= dat_i;
                x_q   <= x_i;
                y_q   <= y_i;
                tag_q <= tag_i;
            end
        end
    end

    assign vld_o = vld_q;
    assign dat_o = dat_q;
    assign x_o   = x_q;
    assign y_o   = y_q;
    assign tag_o = tag_q;

endmodule

// File: rtl/median_filter_seq.sv
// rtl/median_filter_seq.sv - raster frame sequencer with flush injection; MEDIAN_FILTER_SEQ_STAT_EN enables frame_cnt
module median_filter_seq
    import median_filter_pkg::*;
#(
    parameter int DW_PX  = 8,
    parameter int DW_DIM = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DW_DIM-1:0] iw,
    input  logic [DW_DIM-1:0] ih,
    input  logic              s_vld,
    output logic              s_rdy,
    input  logic [DW_PX-1:0]  s_dat,
    output logic              m_vld,
    input  logic              m_rdy,
    output logic [DW_PX-1:0]  m_dat,
    output logic [DW_DIM-1:0] m_x,
    output logic [DW_DIM-1:0] m_y,
    output logic              m_sof,
    output logic              m_eol,
    output logic              m_eof,
    output logic              m_bord,
    output logic              m_flush,
    output logic              busy,
    output logic              frame_done,
    output logic              cfg_err,
    output logic [15:0]       frame_cnt
);

    seq_state_e        state_q;
    logic [DW_DIM-1:0] x_q;
    logic [DW_DIM-1:0] y_q;
    logic [DW_DIM-1:0] iw_q;
    logic [DW_DIM-1:0] ih_q;
    logic [DW_DIM-1:0] fx_q;
    logic [DW_DIM:0]   fcnt_q;
    logic              cfg_err_q;
    logic              frame_done_q;

    logic              oreg_free;
    logic              ld;
    logic [DW_PX-1:0]  ld_dat;
    logic [DW_DIM-1:0] ld_x;
    logic [DW_DIM-1:0] ld_y;
    seq_tag_t          ld_tag;
    seq_tag_t          m_tag;
    logic              geom_ok;
    logic              at_eol;
    logic              at_last_row;
    logic [DW_DIM:0]   fcnt_d;

    assign geom_ok     = (iw >= DW_DIM'(MIN_DIM)) && (ih >= DW_DIM'(MIN_DIM));
    assign at_eol      = (x_q == iw_q - DW_DIM'(1));
    assign at_last_row = (y_q == ih_q - DW_DIM'(1));
    // One extra bit so a full-scale width still yields a non-zero flush length.
    assign fcnt_d      = {1'b0, iw_q} + (DW_DIM+1)'(1);

    assign s_rdy = (state_q == SEQ_RUN) && oreg_free;

    always_comb begin
        ld     = 1'b0;
        ld_dat = '0;
        ld_x   = x_q;
        ld_y   = y_q;
        ld_tag = '0;
        case (state_q)
            SEQ_RUN: begin
                ld          = s_vld && s_rdy;
                ld_dat      = s_dat;
                ld_tag.sof  = (x_q == '0) && (y_q == '0);
                ld_tag.eol  = at_eol;
                ld_tag.eof  = at_eol && at_last_row;
                ld_tag.bord = (x_q == '0) || (y_q == '0) || at_eol || at_last_row;
            end
            SEQ_FLUSH: begin
                ld           = oreg_free;
                ld_x         = fx_q;
                ld_y         = ih_q;
                ld_tag.flush = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= SEQ_IDLE;
            x_q          <= '0;
            y_q          <= '0;
            iw_q         <= '0;
            ih_q         <= '0;
            fx_q         <= '0;
            fcnt_q       <= '0;
            cfg_err_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                SEQ_IDLE: begin
                    if (en) begin
                        if (geom_ok) begin
                            iw_q      <= iw;
                            ih_q      <= ih;
                            x_q       <= '0;
                            y_q       <= '0;
                            cfg_err_q <= 1'b0;
                            state_q   <= SEQ_RUN;
                        end else begin
                            cfg_err_q <= 1'b1;
                        end
                    end
                end
                SEQ_RUN: begin
                    if (ld) begin
                        if (at_eol) begin
                            x_q <= '0;
                            y_q <= y_q + DW_DIM'(1);
                            if (at_last_row) begin
                                fcnt_q  <= fcnt_d;
                                fx_q    <= '0;
                                state_q <= SEQ_FLUSH;
                            end
                        end else begin
                            x_q <= x_q + DW_DIM'(1);
                        end
                    end
                end
                SEQ_FLUSH: begin
                    if (ld) begin
                        fx_q   <= fx_q + DW_DIM'(1);
                        fcnt_q <= fcnt_q - (DW_DIM+1)'(1);
                        if (fcnt_q == (DW_DIM+1)'(1)) begin
                            state_q <= SEQ_DONE;
                        end
                    end
                end
                SEQ_DONE: begin
                    if (oreg_free) begin
                        frame_done_q <= 1'b1;
                        state_q      <= SEQ_IDLE;
                    end
                end
                default: state_q <= SEQ_IDLE;
            endcase
        end
    end

    median_filter_seq_oreg #(
        .DW_PX  (DW_PX),
        .DW_DIM (DW_DIM)
    ) u_oreg (
        .clk    (clk),
        .rst    (rst),
        .ld_i   (ld),
        .dat_i  (ld_dat),
        .x_i    (ld_x),
        .y_i    (ld_y),
        .tag_i  (ld_tag),
        .rdy_i  (m_rdy),
        .free_o (oreg_free),
        .vld_o  (m_vld),
        .dat_o  (m_dat),
        .x_o    (m_x),
        .y_o    (m_y),
        .tag_o  (m_tag)
    );

    assign m_sof      = m_tag.sof;
    assign m_eol      = m_tag.eol;
    assign m_eof      = m_tag.eof;
    assign m_bord     = m_tag.bord;
    assign m_flush    = m_tag.flush;
    assign busy       = (state_q != SEQ_IDLE);
    assign frame_done = frame_done_q;
    assign cfg_err    = cfg_err_q;

`ifdef MEDIAN_FILTER_SEQ_STAT_EN
    logic [15:0] frame_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_q <= '0;
        end else if (frame_done_q) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
`else
    assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_median_filter_seq.sv
// tb/tb_median_filter_seq.sv - directed self-checking bench for median_filter_seq
module tb_median_filter_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic [15:0] iw = 16'd3;
    logic [15:0] ih = 16'd3;
    logic        s_vld = 1'b0;
    logic        s_rdy;
    logic [7:0]  s_dat = 8'd0;
    logic        m_vld;
    logic        m_rdy = 1'b1;
    logic [7:0]  m_dat;
    logic [15:0] m_x;
    logic [15:0] m_y;
    logic        m_sof, m_eol, m_eof, m_bord, m_flush;
    logic        busy, frame_done, cfg_err;
    logic [15:0] frame_cnt;

    median_filter_seq #(.DW_PX(8), .DW_DIM(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .iw         (iw),
        .ih         (ih),
        .s_vld      (s_vld),
        .s_rdy      (s_rdy),
        .s_dat      (s_dat),
        .m_vld      (m_vld),
        .m_rdy      (m_rdy),
        .m_dat      (m_dat),
        .m_x        (m_x),
        .m_y        (m_y),
        .m_sof      (m_sof),
        .m_eol      (m_eol),
        .m_eof      (m_eof),
        .m_bord     (m_bord),
        .m_flush    (m_flush),
        .busy       (busy),
        .frame_done (frame_done),
        .cfg_err    (cfg_err),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  dat;
        logic [15:0] x;
        logic [15:0] y;
        logic        sof;
        logic        eol;
        logic        eof;
        logic        bord;
        logic        flush;
    } beat_t;

    beat_t cur;
    assign cur = {m_dat, m_x, m_y, m_sof, m_eol, m_eof, m_bord, m_flush};

    beat_t beats[$];
    int    beat_cyc[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    fd_cnt = 0;
    int    fd_cyc = 0;
    int    pix = 0;
    logic  bp = 1'b0;
    logic  stalled = 1'b0;
    beat_t snap = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        logic s_hs;
        @(negedge clk);
        if (stalled) check("hold", 64'({m_vld, cur}), 64'({1'b1, snap}));
        stalled = m_vld && !m_rdy;
        snap    = cur;
        if (m_vld && m_rdy) begin
            beats.push_back(cur);
            beat_cyc.push_back(cyc);
        end
        if (frame_done) begin
            fd_cnt++;
            fd_cyc = cyc;
        end
        s_hs = s_vld && s_rdy;
        @(posedge clk);
        #1;
        cyc++;
        if (s_hs) pix++;
        s_dat = 8'(pix);
        m_rdy = bp ? !m_rdy : 1'b1;
    endtask

    task automatic run_frame(input string nm, input int w, input int h, input logic use_bp,
                             input int chg_at, input int budget);
        int n0;
        int k;
        n0 = fd_cnt;
        k  = 0;
        beats.delete();
        beat_cyc.delete();
        iw = 16'(w);
        ih = 16'(h);
        pix = 0;
        s_dat = 8'd0;
        s_vld = 1'b1;
        bp = use_bp;
        en = 1'b1;
        tick();
        if (chg_at < 0) en = 1'b0;
        while (fd_cnt == n0 && k < budget) begin
            if (chg_at >= 0 && pix == chg_at) begin
                iw = 16'd8;
                en = 1'b0;
            end
            tick();
            k++;
        end
        check({nm, ".timeout"}, 64'(k < budget), 64'd1);
        s_vld = 1'b0;
        bp = 1'b0;
        m_rdy = 1'b1;
        en = 1'b0;
    endtask

    task automatic verify(input string nm, input int w, input int h, input int nreal, input int nflush);
        int nr;
        int nf;
        nr = 0;
        nf = 0;
        foreach (beats[i]) begin
            if (beats[i].flush) begin
                check({nm, ".fdat"}, 64'(beats[i].dat), 64'd0);
                check({nm, ".fx"}, 64'(beats[i].x), 64'(nf));
                check({nm, ".fy"}, 64'(beats[i].y), 64'(h));
                check({nm, ".ftag"}, 64'({beats[i].sof, beats[i].eol, beats[i].eof, beats[i].bord}), 64'd0);
                nf++;
            end else begin
                check({nm, ".dat"}, 64'(beats[i].dat), 64'(nr & 255));
                check({nm, ".x"}, 64'(beats[i].x), 64'(nr % w));
                check({nm, ".y"}, 64'(beats[i].y), 64'(nr / w));
                nr++;
            end
        end
        check({nm, ".nreal"}, 64'(nr), 64'(nreal));
        check({nm, ".nflush"}, 64'(nf), 64'(nflush));
    endtask

    function automatic logic [31:0] mask(input int sel);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < beats.size() && i < 32; i++) begin
            logic [4:0] t;
            t = {beats[i].sof, beats[i].eol, beats[i].eof, beats[i].bord, beats[i].flush};
            m[i] = t[3'(4 - sel)];
        end
        return m;
    endfunction

    initial begin
        int n0;
        int k;
        int nsof;

        #2 rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst.s_rdy", 64'(s_rdy), 64'd0);
        check("rst.m_vld", 64'(m_vld), 64'd0);
        check("rst.busy", 64'(busy), 64'd0);
        check("rst.frame_done", 64'(frame_done), 64'd0);
        check("rst.cfg_err", 64'(cfg_err), 64'd0);
        check("rst.frame_cnt", 64'(frame_cnt), 64'd0);
        check("rst.beat", 64'(cur), 64'd0);

        // Minimal 3x3 frame, no backpressure.
        run_frame("min", 3, 3, 1'b0, -1, 100);
        verify("min", 3, 3, 9, 4);
        check("min.sof", 64'(mask(0)), 64'h001);
        check("min.eol", 64'(mask(1)), 64'h124);
        check("min.eof", 64'(mask(2)), 64'h100);
        check("min.bord", 64'(mask(3)), 64'h1EF);
        check("min.flush", 64'(mask(4)), 64'h1E00);
        check("min.fd_lat", 64'(fd_cyc - beat_cyc[beat_cyc.size()-1]), 64'd1);
        tick();
        check("min.idle", 64'(busy), 64'd0);

        // 4x3 frame with m_rdy toggling every cycle.
        run_frame("bp", 4, 3, 1'b1, -1, 200);
        verify("bp", 4, 3, 12, 5);
        check("bp.sof", 64'(mask(0)), 64'h001);
        check("bp.eol", 64'(mask(1)), 64'h888);
        check("bp.eof", 64'(mask(2)), 64'h800);
        check("bp.bord", 64'(mask(3)), 64'hF9F);
        check("bp.flush", 64'(mask(4)), 64'h1F000);
        repeat (2) tick();

        // Illegal geometry, then a legal width starts the frame.
        iw = 16'd2;
        ih = 16'd480;
        en = 1'b1;
        repeat (3) tick();
        check("geo.cfg_err", 64'(cfg_err), 64'd1);
        check("geo.busy", 64'(busy), 64'd0);
        check("geo.s_rdy", 64'(s_rdy), 64'd0);
        iw = 16'd640;
        tick();
        check("geo.busy_start", 64'(busy), 64'd1);
        check("geo.cfg_clr", 64'(cfg_err), 64'd0);
        en = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        // 5x4 frame: width and enable change after the third pixel.
        run_frame("chg", 5, 4, 1'b0, 3, 200);
        verify("chg", 5, 4, 20, 6);
        repeat (5) tick();
        check("chg.idle_busy", 64'(busy), 64'd0);
        check("chg.idle_s_rdy", 64'(s_rdy), 64'd0);

        // Reset at pixel 7 of a 4x3 frame.
        iw = 16'd4;
        ih = 16'd3;
        pix = 0;
        s_dat = 8'd0;
        s_vld = 1'b1;
        en = 1'b1;
        tick();
        en = 1'b0;
        k = 0;
        while (pix < 7 && k < 50) begin
            tick();
            k++;
        end
        check("rstmid.reach", 64'(pix), 64'd7);
        n0 = fd_cnt;
        rst = 1'b1;
        tick();
        check("rstmid.m_vld", 64'(m_vld), 64'd0);
        check("rstmid.s_rdy", 64'(s_rdy), 64'd0);
        check("rstmid.busy", 64'(busy), 64'd0);
        check("rstmid.beat", 64'(cur), 64'd0);
        check("rstmid.cfg_err", 64'(cfg_err), 64'd0);
        rst = 1'b0;
        s_vld = 1'b0;
        repeat (10) tick();
        check("rstmid.no_done", 64'(fd_cnt), 64'(n0));
        check("rstmid.frame_cnt", 64'(frame_cnt), 64'd0);
        check("rstmid.idle", 64'(busy), 64'd0);

        // Three back-to-back 3x3 frames.
        beats.delete();
        beat_cyc.delete();
        n0 = fd_cnt;
        iw = 16'd3;
        ih = 16'd3;
        s_vld = 1'b1;
        en = 1'b1;
        k = 0;
        while (fd_cnt < n0 + 3 && k < 300) begin
            tick();
            if (fd_cnt >= n0 + 2) en = 1'b0;
            k++;
        end
        check("stat.timeout", 64'(k < 300), 64'd1);
        s_vld = 1'b0;
        repeat (3) tick();
        check("stat.beats", 64'(beats.size()), 64'd39);
`ifdef MEDIAN_FILTER_SEQ_STAT_EN
        check("stat.frame_cnt", 64'(frame_cnt), 64'd3);
`else
        check("stat.frame_cnt", 64'(frame_cnt), 64'd0);
`endif
        nsof = 0;
        foreach (beats[i]) begin
            if (beats[i].sof) begin
                nsof++;
                if (i > 0) check("stat.gap", 64'(beat_cyc[i] - beat_cyc[i-1]), 64'd3);
            end
        end
        check("stat.nsof", 64'(nsof), 64'd3);
        check("stat.idle", 64'(busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
